// File: rtl/vtg_pkg.sv
// Shared timing defaults, pixel type helpers and colour-bar table for the
// video timing generator.
`timescale 1ns/1ps
package vtg_pkg;

    localparam int unsigned CNT_W     = 11;
    localparam int unsigned MAX_TOTAL = 2048;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    typedef logic [23:0] pixel_t;

    function automatic int unsigned axis_total(
        input int unsigned act,
        input int unsigned fp,
        input int unsigned sw,
        input int unsigned bp
    );
        return act + fp + sw + bp;
    endfunction

    function automatic int unsigned h_total_def();
        return axis_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
    endfunction

    function automatic int unsigned v_total_def();
        return axis_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);
    endfunction

    function automatic logic [7:0] red_of(input pixel_t p);
        return p[23:16];
    endfunction

    function automatic logic [7:0] green_of(input pixel_t p);
        return p[15:8];
    endfunction

    function automatic logic [7:0] blue_of(input pixel_t p);
        return p[7:0];
    endfunction

    localparam pixel_t COLOR_BARS [8] = '{
        24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
    };

endpackage

// File: rtl/vtg_axis_counter.sv
// Wrapping raster axis counter with active-region and sync-window decode.
`timescale 1ns/1ps
import vtg_pkg::*;

module vtg_axis_counter #(
    parameter int unsigned ACTIVE     = 640,
    parameter int unsigned SYNC_START = 656,
    parameter int unsigned SYNC_END   = 752,
    parameter int unsigned TOTAL      = 800
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             wrap,
    output logic             active,
    output logic             sync
);

    assign wrap   = en && (32'(cnt) == TOTAL - 1);
    assign active = 32'(cnt) < ACTIVE;
    assign sync   = (32'(cnt) >= SYNC_START) && (32'(cnt) < SYNC_END);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= wrap ? '0 : cnt + 11'd1;
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing + pixel fetch pipeline feeding the TMDS encoders.
// Define VTG_TESTPATTERN_EN to replace PixData with 8 vertical colour bars.
`timescale 1ns/1ps
import vtg_pkg::*;

module video_timing_gen #(
    parameter int unsigned H_ACTIVE  = DEF_H_ACTIVE,
    parameter int unsigned H_FP      = DEF_H_FP,
    parameter int unsigned H_SYNC    = DEF_H_SYNC,
    parameter int unsigned H_BP      = DEF_H_BP,
    parameter int unsigned V_ACTIVE  = DEF_V_ACTIVE,
    parameter int unsigned V_FP      = DEF_V_FP,
    parameter int unsigned V_SYNC    = DEF_V_SYNC,
    parameter int unsigned V_BP      = DEF_V_BP,
    parameter bit          HSYNC_POL = 1'b0,
    parameter bit          VSYNC_POL = 1'b0
) (
    input  logic        PixClk,
    input  logic        Reset,
    output logic        ReqValid,
    output logic [10:0] ReqX,
    output logic [10:0] ReqY,
    input  logic [23:0] PixData,
    output logic        DE,
    output logic        HSync,
    output logic        VSync,
    output logic [7:0]  Red,
    output logic [7:0]  Green,
    output logic [7:0]  Blue,
    output logic        FrameStart
);

    localparam int unsigned H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_bad_timing
        $error("video_timing_gen: H_TOTAL/V_TOTAL exceed 11-bit counters");
    end

    logic [CNT_W-1:0] h_cnt, v_cnt;
    logic h_wrap, v_wrap, h_act, v_act, h_sync, v_sync;
    logic origin, hs_d1, vs_d1, first_d1;
    pixel_t pix_src;

    vtg_axis_counter #(
        .ACTIVE(H_ACTIVE), .SYNC_START(H_ACTIVE + H_FP),
        .SYNC_END(H_ACTIVE + H_FP + H_SYNC), .TOTAL(H_TOTAL)
    ) u_h (
        .clk(PixClk), .rst(Reset), .en(1'b1),
        .cnt(h_cnt), .wrap(h_wrap), .active(h_act), .sync(h_sync)
    );

    vtg_axis_counter #(
        .ACTIVE(V_ACTIVE), .SYNC_START(V_ACTIVE + V_FP),
        .SYNC_END(V_ACTIVE + V_FP + V_SYNC), .TOTAL(V_TOTAL)
    ) u_v (
        .clk(PixClk), .rst(Reset), .en(h_wrap),
        .cnt(v_cnt), .wrap(v_wrap), .active(v_act), .sync(v_sync)
    );

    // High exactly while the counters sit at (0,0).
    always_ff @(posedge PixClk or posedge Reset) begin
        if (Reset) origin <= 1'b1;
        else       origin <= v_wrap;
    end

    always_ff @(posedge PixClk or posedge Reset) begin
        if (Reset) begin
            ReqValid <= 1'b0;
            ReqX     <= '0;
            ReqY     <= '0;
            hs_d1    <= 1'b0;
            vs_d1    <= 1'b0;
            first_d1 <= 1'b0;
        end else begin
            ReqValid <= h_act && v_act;
            if (h_act && v_act) begin
                ReqX <= h_cnt;
                ReqY <= v_cnt;
            end
            hs_d1    <= h_sync;
            vs_d1    <= v_sync;
            first_d1 <= origin;
        end
    end

`ifdef VTG_TESTPATTERN_EN
    localparam int unsigned BAR_W = H_ACTIVE / 8;

    logic [CNT_W-1:0] bar_px;
    logic [2:0]       bar_idx;
    logic             unused_pix;

    assign unused_pix = ^PixData;

    // Tracks the bar of the pixel currently requested in stage 1.
    always_ff @(posedge PixClk or posedge Reset) begin
        if (Reset) begin
            bar_px  <= '0;
            bar_idx <= '0;
        end else if (h_cnt == '0) begin
            bar_px  <= '0;
            bar_idx <= '0;
        end else if (h_act) begin
            if (32'(bar_px) == BAR_W - 1) begin
                bar_px  <= '0;
                bar_idx <= bar_idx + 3'd1;
            end else begin
                bar_px  <= bar_px + 11'd1;
            end
        end
    end

    assign pix_src = COLOR_BARS[bar_idx];
`else
    assign pix_src = PixData;
`endif

    always_ff @(posedge PixClk or posedge Reset) begin
        if (Reset) begin
            DE         <= 1'b0;
            Red        <= '0;
            Green      <= '0;
            Blue       <= '0;
            HSync      <= ~HSYNC_POL;
            VSync      <= ~VSYNC_POL;
            FrameStart <= 1'b0;
        end else begin
            DE         <= ReqValid;
            Red        <= ReqValid ? red_of(pix_src)   : 8'h00;
            Green      <= ReqValid ? green_of(pix_src) : 8'h00;
            Blue       <= ReqValid ? blue_of(pix_src)  : 8'h00;
            HSync      <= hs_d1 ~^ HSYNC_POL;
            VSync      <= vs_d1 ~^ VSYNC_POL;
            FrameStart <= first_d1;
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen using a reduced raster (25x10) so
// whole frames, sync windows and mid-frame reset fit in a short run.
`timescale 1ns/1ps

module tb_video_timing_gen;

    localparam int HA  = 16;
    localparam int HFP = 2;
    localparam int HS  = 4;
    localparam int HB  = 3;
    localparam int VA  = 6;
    localparam int VFP = 1;
    localparam int VS  = 2;
    localparam int VB  = 1;
    localparam int HT  = HA + HFP + HS + HB;
    localparam int VT  = VA + VFP + VS + VB;
    localparam int FT  = HT * VT;

    logic        PixClk = 1'b0;
    logic        Reset  = 1'b1;
    logic        ReqValid;
    logic [10:0] ReqX, ReqY;
    logic [23:0] PixData;
    logic        DE, HSync, VSync, FrameStart;
    logic [7:0]  Red, Green, Blue;

    int checks   = 0;
    int failures = 0;

`ifdef VTG_TESTPATTERN_EN
    logic [23:0] bars [8] = '{
        24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
    };
`endif

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VB),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
    ) dut (
        .PixClk(PixClk), .Reset(Reset),
        .ReqValid(ReqValid), .ReqX(ReqX), .ReqY(ReqY),
        .PixData(PixData),
        .DE(DE), .HSync(HSync), .VSync(VSync),
        .Red(Red), .Green(Green), .Blue(Blue),
        .FrameStart(FrameStart)
    );

    always #5 PixClk = ~PixClk;

    // Source answers with fixed one-cycle latency; junk when idle.
    assign PixData = ReqValid ? {ReqX[7:0], ReqY[7:0], 8'hA5} : 24'h5A5A5A;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge PixClk);
        #1;
    endtask

    task automatic check_reset(input string ph);
        chk({ph, "_req_valid"}, 32'(ReqValid), 32'(0));
        chk({ph, "_req_x"}, 32'(ReqX), 32'(0));
        chk({ph, "_req_y"}, 32'(ReqY), 32'(0));
        chk({ph, "_de"}, 32'(DE), 32'(0));
        chk({ph, "_hsync"}, 32'(HSync), 32'(1));
        chk({ph, "_vsync"}, 32'(VSync), 32'(1));
        chk({ph, "_fs"}, 32'(FrameStart), 32'(0));
        chk({ph, "_rgb"}, 32'({Red, Green, Blue}), 32'(0));
    endtask

    // n = number of rising edges since reset release.
    task automatic check_out(input int n);
        int p, h, v;
        logic e_de, e_hs, e_vs, e_fs, e_rv;
        logic [23:0] e_rgb;
        e_de = 0; e_hs = 1; e_vs = 1; e_fs = 0; e_rgb = '0;
        if (n >= 2) begin
            p = (n - 2) % FT;
            h = p % HT;
            v = p / HT;
            e_de = (h < HA) && (v < VA);
            e_hs = !((h >= HA + HFP) && (h < HA + HFP + HS));
            e_vs = !((v >= VA + VFP) && (v < VA + VFP + VS));
            e_fs = (p == 0);
            if (e_de) begin
`ifdef VTG_TESTPATTERN_EN
                e_rgb = bars[h / (HA / 8)];
`else
                e_rgb = {h[7:0], v[7:0], 8'hA5};
`endif
            end
        end
        chk($sformatf("de@%0d", n), 32'(DE), 32'(e_de));
        chk($sformatf("hsync@%0d", n), 32'(HSync), 32'(e_hs));
        chk($sformatf("vsync@%0d", n), 32'(VSync), 32'(e_vs));
        chk($sformatf("fs@%0d", n), 32'(FrameStart), 32'(e_fs));
        chk($sformatf("rgb@%0d", n), 32'({Red, Green, Blue}), 32'(e_rgb));
        e_rv = 0;
        h = 0;
        v = 0;
        if (n >= 1) begin
            p = (n - 1) % FT;
            h = p % HT;
            v = p / HT;
            e_rv = (h < HA) && (v < VA);
        end
        chk($sformatf("req_valid@%0d", n), 32'(ReqValid), 32'(e_rv));
        if (e_rv) begin
            chk($sformatf("req_x@%0d", n), 32'(ReqX), 32'(h));
            chk($sformatf("req_y@%0d", n), 32'(ReqY), 32'(v));
        end
    endtask

    initial begin
        int n, m, last_fs;

        repeat (3) tick();
        check_reset("por");
        @(negedge PixClk);
        Reset = 1'b0;

        last_fs = -1;
        for (n = 1; n <= 2 * FT + 4; n++) begin
            tick();
            check_out(n);
            if (FrameStart) begin
                if (last_fs >= 0) chk("fs_period", 32'(n - last_fs), 32'(FT));
                last_fs = n;
            end
        end

        // Run on until the counters reach (10,3), then reset mid-frame.
        m = 0;
        for (int k = 0; k < FT; k++) begin
            tick();
            check_out(n);
            m = n;
            n++;
            if (m % FT == 3 * HT + 10) break;
        end
        chk("mid_point", 32'(m % FT), 32'(3 * HT + 10));

        #2 Reset = 1'b1;
        #1 check_reset("mid");
        tick();
        check_reset("hold");
        @(negedge PixClk);
        Reset = 1'b0;

        last_fs = -1;
        for (n = 1; n <= FT + 4; n++) begin
            tick();
            check_out(n);
            if (FrameStart) begin
                if (last_fs >= 0) chk("fs_period2", 32'(n - last_fs), 32'(FT));
                last_fs = n;
            end
        end
        chk("fs_last_pos", 32'(last_fs), 32'(FT + 2));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
